// File: rtl/seg_scan_mux.sv
// Multiplexed hex seven-segment scanner with a clock divider and shadow registers.
// It also supports per-digit enable and leading-zero blanking.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIVIDE_BY  = 1,
  parameter int FRAME_SYNC = 0
) (
  input  logic                    clk,
  input  logic                    btnC,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    hold,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CW = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIVIDE_BY - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dpr_q, dpr_d;
  logic                    fd_q, fd_d;
  logic                    tick_s;
  logic                    load_s;
  logic [3:0]              nib_s;
  logic [NUM_DIGITS-1:0]   lz_s;
  logic                    zero_above_s;
  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic                    dp_s;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      4'hF:    code = 7'b0001110;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  // Divider, digit index and end-of-frame detection.
  always_comb begin
    tick_s = (cnt_q == LAST_CNT);
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (tick_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end
    fd_d = tick_s && (idx_q == LAST_IDX);
  end

  // Frame-synchronous capture fires on the edge that enters slot 0 at count 0,
  // so every slot of the new frame shows one consistent snapshot.
  always_comb begin
    if (hold) begin
      load_s = 1'b0;
    end else if (FRAME_SYNC != 0) begin
      load_s = (idx_d == '0) && (cnt_d == '0);
    end else begin
      load_s = 1'b1;
    end
    if (load_s) begin
      val_d = value;
      dpr_d = dp_in;
    end else begin
      val_d = val_q;
      dpr_d = dpr_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (btnC) begin
      cnt_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      dpr_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      val_q <= val_d;
      dpr_q <= dpr_d;
      fd_q  <= fd_d;
    end
  end

  // Digit k is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    zero_above_s = 1'b1;
    lz_s         = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s & (val_q[4*k +: 4] == 4'h0);
      lz_s[k]      = zero_above_s && (k != 0);
    end
  end

  // Drive the active digit from registered index and shadow state only.
  always_comb begin
    nib_s = val_q[{idx_q, 2'b00} +: 4];
    an_s  = '1;
    seg_s = 7'b1111111;
    dp_s  = 1'b1;
    if (dig_en[idx_q]) begin
      an_s[idx_q] = 1'b0;
      dp_s        = ~dpr_q[idx_q];
      if (blank_lz && lz_s[idx_q]) begin
        seg_s = 7'b1111111;
      end else begin
        seg_s = seg_encode(nib_s);
      end
    end else begin
      an_s  = '1;
      seg_s = 7'b1111111;
      dp_s  = 1'b1;
    end
  end

  assign an         = an_s;
  assign seg        = seg_s;
  assign dp         = dp_s;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: three instances (divide-by-1, divide-by-3,
// frame-synchronous) checked through an expected-output queue.
module tb_seg_scan_mux;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  typedef struct {
    logic        btn;
    logic [15:0] val;
    logic [3:0]  dpi;
    logic [3:0]  en;
    logic        hld;
    logic        blz;
    exp_t        e;
  } vec_t;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam int NV = 28;

  logic        clk;
  logic        btn_s  [3];
  logic [15:0] val_s  [3];
  logic [3:0]  dpi_s  [3];
  logic [3:0]  en_s   [3];
  logic        hld_s  [3];
  logic        blz_s  [3];
  logic [3:0]  an_w   [3];
  logic [6:0]  seg_w  [3];
  logic        dp_w   [3];
  logic        fd_w   [3];

  exp_t sb_q[$];
  vec_t tv [NV];
  int   n_checks;
  int   n_pass;

  seg_scan_mux #(.NUM_DIGITS(4), .DIVIDE_BY(1), .FRAME_SYNC(0)) u_d1 (
    .clk(clk), .btnC(btn_s[0]), .value(val_s[0]), .dp_in(dpi_s[0]), .dig_en(en_s[0]),
    .hold(hld_s[0]), .blank_lz(blz_s[0]), .an(an_w[0]), .seg(seg_w[0]), .dp(dp_w[0]),
    .frame_done(fd_w[0]));

  seg_scan_mux #(.NUM_DIGITS(4), .DIVIDE_BY(3), .FRAME_SYNC(0)) u_d3 (
    .clk(clk), .btnC(btn_s[1]), .value(val_s[1]), .dp_in(dpi_s[1]), .dig_en(en_s[1]),
    .hold(hld_s[1]), .blank_lz(blz_s[1]), .an(an_w[1]), .seg(seg_w[1]), .dp(dp_w[1]),
    .frame_done(fd_w[1]));

  seg_scan_mux #(.NUM_DIGITS(4), .DIVIDE_BY(1), .FRAME_SYNC(1)) u_fs (
    .clk(clk), .btnC(btn_s[2]), .value(val_s[2]), .dp_in(dpi_s[2]), .dig_en(en_s[2]),
    .hold(hld_s[2]), .blank_lz(blz_s[2]), .an(an_w[2]), .seg(seg_w[2]), .dp(dp_w[2]),
    .frame_done(fd_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  4'hF: return 7'b0001110;
      default: return BLANK;
    endcase
  endfunction

  function automatic exp_t mk_e(input logic [3:0] an, input logic [6:0] sg,
                                input logic dpo, input logic fd);
    exp_t e;
    e.an = an; e.seg = sg; e.dp = dpo; e.fd = fd;
    return e;
  endfunction

  function automatic vec_t mk(input logic btn, input logic [15:0] v, input logic [3:0] dpi,
                              input logic [3:0] en, input logic hd, input logic bl,
                              input logic [3:0] an, input logic [6:0] sg,
                              input logic dpo, input logic fd);
    vec_t t;
    t.btn = btn; t.val = v; t.dpi = dpi; t.en = en; t.hld = hd; t.blz = bl;
    t.e = mk_e(an, sg, dpo, fd);
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
  endtask

  task automatic drive(input int inst, input logic btn, input logic [15:0] v,
                       input logic [3:0] dpi, input logic [3:0] en,
                       input logic hd, input logic bl);
    btn_s[inst] = btn; val_s[inst] = v; dpi_s[inst] = dpi;
    en_s[inst]  = en;  hld_s[inst] = hd; blz_s[inst] = bl;
  endtask

  task automatic check_pop(input int inst, input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s.queue: got empty scoreboard, want one entry", tag);
    end else begin
      e = sb_q.pop_front();
      cmp({tag, ".an"},  {12'h000, an_w[inst]},  {12'h000, e.an});
      cmp({tag, ".seg"}, {9'h000, seg_w[inst]},  {9'h000, e.seg});
      cmp({tag, ".dp"},  {15'h0000, dp_w[inst]}, {15'h0000, e.dp});
      cmp({tag, ".fd"},  {15'h0000, fd_w[inst]}, {15'h0000, e.fd});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last_fd;
    int idx;
    logic [15:0] v;
    logic [3:0] fs_nib [12];
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b0);

    // btn value dp_in en hold blank | an seg dp frame_done
    tv[0]  = mk(1'b1, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1110, seg_of(4'h0), 1'b1, 1'b0);
    tv[1]  = mk(1'b0, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1101, seg_of(4'h5), 1'b1, 1'b0);
    tv[2]  = mk(1'b0, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1011, seg_of(4'hC), 1'b1, 1'b0);
    tv[3]  = mk(1'b0, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b0111, seg_of(4'h3), 1'b1, 1'b0);
    tv[4]  = mk(1'b0, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1110, seg_of(4'hA), 1'b1, 1'b1);
    tv[5]  = mk(1'b0, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1101, seg_of(4'h5), 1'b1, 1'b0);
    tv[6]  = mk(1'b0, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1011, seg_of(4'hC), 1'b1, 1'b0);
    tv[7]  = mk(1'b0, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b0111, seg_of(4'h3), 1'b1, 1'b0);
    tv[8]  = mk(1'b0, 16'h3C5A, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1110, seg_of(4'hA), 1'b1, 1'b1);
    tv[9]  = mk(1'b0, 16'h0040, 4'h0, 4'hF, 1'b0, 1'b1, 4'b1101, seg_of(4'h4), 1'b1, 1'b0);
    tv[10] = mk(1'b0, 16'h0040, 4'h0, 4'hF, 1'b0, 1'b1, 4'b1011, BLANK,        1'b1, 1'b0);
    tv[11] = mk(1'b0, 16'h0040, 4'h0, 4'hF, 1'b0, 1'b1, 4'b0111, BLANK,        1'b1, 1'b0);
    tv[12] = mk(1'b0, 16'h0040, 4'h0, 4'hF, 1'b0, 1'b1, 4'b1110, seg_of(4'h0), 1'b1, 1'b1);
    tv[13] = mk(1'b0, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b1, 4'b1101, BLANK,        1'b1, 1'b0);
    tv[14] = mk(1'b0, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b1, 4'b1011, BLANK,        1'b1, 1'b0);
    tv[15] = mk(1'b0, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b1, 4'b0111, BLANK,        1'b1, 1'b0);
    tv[16] = mk(1'b0, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b1, 4'b1110, seg_of(4'h0), 1'b1, 1'b1);
    tv[17] = mk(1'b0, 16'h1234, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1101, seg_of(4'h3), 1'b1, 1'b0);
    tv[18] = mk(1'b0, 16'h5678, 4'h0, 4'hF, 1'b1, 1'b0, 4'b1011, seg_of(4'h2), 1'b1, 1'b0);
    tv[19] = mk(1'b0, 16'h5678, 4'h0, 4'hF, 1'b1, 1'b0, 4'b0111, seg_of(4'h1), 1'b1, 1'b0);
    tv[20] = mk(1'b0, 16'h5678, 4'h0, 4'hF, 1'b0, 1'b0, 4'b1110, seg_of(4'h8), 1'b1, 1'b1);
    tv[21] = mk(1'b0, 16'h5678, 4'h1, 4'hB, 1'b0, 1'b0, 4'b1101, seg_of(4'h7), 1'b1, 1'b0);
    tv[22] = mk(1'b0, 16'h5678, 4'h1, 4'hB, 1'b0, 1'b0, 4'b1111, BLANK,        1'b1, 1'b0);
    tv[23] = mk(1'b1, 16'h5678, 4'h1, 4'hB, 1'b1, 1'b0, 4'b1110, seg_of(4'h0), 1'b1, 1'b0);
    tv[24] = mk(1'b0, 16'h5678, 4'h1, 4'hB, 1'b0, 1'b0, 4'b1101, seg_of(4'h7), 1'b1, 1'b0);
    tv[25] = mk(1'b0, 16'h5678, 4'h1, 4'hB, 1'b0, 1'b0, 4'b1111, BLANK,        1'b1, 1'b0);
    tv[26] = mk(1'b0, 16'h5678, 4'h1, 4'hB, 1'b0, 1'b0, 4'b0111, seg_of(4'h5), 1'b1, 1'b0);
    tv[27] = mk(1'b0, 16'h5678, 4'h1, 4'hB, 1'b0, 1'b0, 4'b1110, seg_of(4'h8), 1'b0, 1'b1);

    // Divide-by-1 instance: scan order, blanking, hold, enables, mid-frame reset.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(0, tv[i].btn, tv[i].val, tv[i].dpi, tv[i].en, tv[i].hld, tv[i].blz);
      sb_q.push_back(tv[i].e);
      @(posedge clk); #1;
      check_pop(0, $sformatf("d1.vec%0d", i));
    end

    // Divide-by-3 instance: three cycles per slot, frame_done every 12 cycles.
    last_fd = -1;
    v = 16'h3C5A;
    for (int k = 0; k < 38; k++) begin
      @(negedge clk);
      drive(1, (k == 0), v, 4'h0, 4'hF, 1'b0, 1'b0);
      idx = (k / 3) % 4;
      if (k == 0) sb_q.push_back(mk_e(4'b1110, seg_of(4'h0), 1'b1, 1'b0));
      else sb_q.push_back(mk_e(~(4'b0001 << idx), seg_of(v[4*idx +: 4]), 1'b1,
                               (k % 12 == 0)));
      @(posedge clk); #1;
      check_pop(1, $sformatf("d3.k%0d", k));
      if (fd_w[1]) begin
        if (last_fd >= 0) cmp($sformatf("d3.fd_gap%0d", k), 16'(k - last_fd), 16'd12);
        last_fd = k;
      end
    end

    // Frame-sync instance: a mid-frame value change waits for the next frame.
    fs_nib = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h3, 4'h2, 4'h1, 4'hD, 4'hC, 4'hB, 4'hA};
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      drive(2, (s == 0), (s < 6) ? 16'h1234 : 16'hABCD, 4'h0, 4'hF, 1'b0, 1'b0);
      sb_q.push_back(mk_e(~(4'b0001 << (s % 4)), seg_of(fs_nib[s]), 1'b1,
                          (s == 4) || (s == 8)));
      @(posedge clk); #1;
      check_pop(2, $sformatf("fs.s%0d", s));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
